// File: rtl/mc_controller_hs_if.sv
// Control-path bus of the multi-cycle CPU: instruction fields and the memory
// ready handshake in, datapath controls and status out.
interface mc_controller_hs_if #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 32
);
  logic [5:0]         OpCode;
  logic [5:0]         Funct;
  logic               mem_ready;
  logic               PCWrite, PCWriteCond, IorD, MemWrite, MemRead;
  logic               IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0]         MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic [3:0]         state_out;
  logic               halted, illegal, timeout;
  logic [CNT_W-1:0]   instr_count;

  // Controller side
  modport master (
    input  OpCode, Funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite,
           ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           state_out, halted, illegal, timeout, instr_count
  );

  // Datapath / memory side
  modport slave (
    output OpCode, Funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite,
           ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           state_out, halted, illegal, timeout, instr_count
  );
endinterface

// File: rtl/mc_controller_hs.sv
// Multi-cycle main control FSM with memory ready handshake, wait-state
// timeout, illegal-instruction trap and retired-instruction counter.
module mc_controller_hs #(
  parameter int unsigned ALUOP_W         = 4,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned MEM_TIMEOUT     = 16,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  mc_controller_hs_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4, S_WB_MEM = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
    S_WB_ALU = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_JR = 4'd11,
    S_HALT = 4'd15
  } state_t;

  localparam int unsigned WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [WC_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] instr_count;
  logic             halted, illegal, timeout;
  logic             retire, set_illegal, set_timeout, waiting, wait_expired;
  logic [5:0]       op, fn;

  assign op = bus.OpCode;
  assign fn = bus.Funct;

  assign waiting      = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign wait_expired = (wait_cnt == WC_LAST) && !bus.mem_ready;

  // Next-state selection and Moore control decode (FETCH strobes gated by mem_ready)
  always_comb begin
    state_nxt        = state;
    retire           = 1'b0;
    set_illegal      = 1'b0;
    set_timeout      = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.IorD         = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.ExtOp        = 1'b0;
    bus.LuiOp        = 1'b0;
    bus.MemtoReg     = 2'b00;
    bus.RegDst       = 2'b00;
    bus.ALUSrcA      = 2'b00;
    bus.ALUSrcB      = 2'b00;
    bus.PCSource     = 2'b00;
    bus.ALUOp        = '0;
    unique case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_nxt   = S_DECODE;
        end else if (wait_expired) begin
          set_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.ExtOp   = 1'b1;
        unique case (op)
          6'h23, 6'h2B: state_nxt = S_MEM_ADDR;
          6'h00:        state_nxt = (fn == 6'h08 || fn == 6'h09) ? S_JR : S_EXEC_R;
          6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: state_nxt = S_EXEC_I;
          6'h04:        state_nxt = S_BRANCH;
          6'h02, 6'h03: state_nxt = S_JUMP;
          default: begin
            set_illegal = 1'b1;
            state_nxt   = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.ExtOp   = 1'b1;
        state_nxt   = (op == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) state_nxt = S_WB_MEM;
        else if (wait_expired) begin
          set_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else if (wait_expired) begin
          set_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end
      S_WB_MEM: begin
        bus.RegWrite = 1'b1;
        state_nxt    = S_FETCH;
        retire       = 1'b1;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01;
        bus.ALUOp   = ALUOP_W'(2);
        state_nxt   = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.ExtOp   = !(op == 6'h0C || op == 6'h0D || op == 6'h0B);
        bus.LuiOp   = (op == 6'h0F);
        unique case (op)
          6'h0C:   bus.ALUOp = ALUOP_W'(3);
          6'h0D:   bus.ALUOp = ALUOP_W'(4);
          6'h0A:   bus.ALUOp = ALUOP_W'(5);
          6'h0B:   bus.ALUOp = ALUOP_W'(6);
          default: bus.ALUOp = ALUOP_W'(0);
        endcase
        state_nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'b01;
        bus.RegDst   = (op == 6'h00) ? 2'b01 : 2'b00;
        state_nxt    = S_FETCH;
        retire       = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 2'b01;
        bus.ALUOp       = ALUOP_W'(1);
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        state_nxt       = S_FETCH;
        retire          = 1'b1;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        if (op == 6'h03) begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'b10;
          bus.MemtoReg = 2'b10;
        end
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_JR: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b11;
        if (fn == 6'h09) begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'b01;
          bus.MemtoReg = 2'b10;
        end
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, wait counter, sticky status flags and retire counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (waiting && state_nxt == state) wait_cnt <= wait_cnt + 1'b1;
      else                               wait_cnt <= '0;
      if (retire) instr_count <= instr_count + 1'b1;
      halted  <= halted  | (state_nxt == S_HALT);
      illegal <= illegal | set_illegal;
      timeout <= timeout | set_timeout;
    end
  end

  assign bus.state_out   = state;
  assign bus.instr_count = instr_count;
  assign bus.halted      = halted;
  assign bus.illegal     = illegal;
  assign bus.timeout     = timeout;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Randomized self-checking bench for mc_controller_hs. Two instances run in
// lockstep on the same stimulus: one traps illegal opcodes, one skips them.
module tb_mc_controller_hs;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_cnt  = 0;
  int unsigned exp_cnt_nt = 0;

  always #5 clk = ~clk;

  mc_controller_hs_if #(.ALUOP_W(4), .CNT_W(32)) bus ();
  mc_controller_hs_if #(.ALUOP_W(4), .CNT_W(32)) bus_nt ();

  assign bus_nt.OpCode    = bus.OpCode;
  assign bus_nt.Funct     = bus.Funct;
  assign bus_nt.mem_ready = bus.mem_ready;

  mc_controller_hs #(.ALUOP_W(4), .CNT_W(32), .MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b1))
    dut (.clk(clk), .reset(reset), .bus(bus));
  mc_controller_hs #(.ALUOP_W(4), .CNT_W(32), .MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b0))
    dut_nt (.clk(clk), .reset(reset), .bus(bus_nt));

  logic [22:0] act_v;
  assign act_v = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemWrite, bus.MemRead,
                  bus.IRWrite, bus.RegWrite, bus.ExtOp, bus.LuiOp, bus.MemtoReg,
                  bus.RegDst, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp};

  // Control set each state must present, straight from the control table
  function automatic logic [22:0] exp_ctrl(input int unsigned st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic rdy);
    logic pcw, pcwc, iord, mw, mr, irw, rw, ext, lui;
    logic [1:0] m2r, rd, sa, sb, pcs;
    logic [3:0] aop;
    {pcw, pcwc, iord, mw, mr, irw, rw, ext, lui} = '0;
    {m2r, rd, sa, sb, pcs} = '0;
    aop = '0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      1:  begin sb = 2'b11; ext = 1; end
      2:  begin sa = 2'b01; sb = 2'b10; ext = 1; end
      3:  begin mr = 1; iord = 1; end
      4:  begin mw = 1; iord = 1; end
      5:  rw = 1;
      6:  begin sa = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01; aop = 4'd2; end
      7:  begin
            sa = 2'b01; sb = 2'b10;
            ext = !(op == 6'h0C || op == 6'h0D || op == 6'h0B);
            lui = (op == 6'h0F);
            aop = (op == 6'h0C) ? 4'd3 : (op == 6'h0D) ? 4'd4 :
                  (op == 6'h0A) ? 4'd5 : (op == 6'h0B) ? 4'd6 : 4'd0;
          end
      8:  begin rw = 1; m2r = 2'b01; rd = (op == 6'h00) ? 2'b01 : 2'b00; end
      9:  begin sa = 2'b01; aop = 4'd1; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; if (op == 6'h03) begin rw = 1; rd = 2'b10; m2r = 2'b10; end end
      11: begin pcw = 1; pcs = 2'b11; if (fn == 6'h09) begin rw = 1; rd = 2'b01; m2r = 2'b10; end end
      default: ;
    endcase
    return {pcw, pcwc, iord, mw, mr, irw, rw, ext, lui, m2r, rd, sa, sb, pcs, aop};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus.mem_ready = 1'($urandom);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_cnt = 0;
    exp_cnt_nt = 0;
  endtask

  // One whole instruction from FETCH back to FETCH; fw/mw = wait cycles before ready
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int unsigned fw, input int unsigned mw);
    int unsigned path[$];
    logic        rq[$];
    for (int unsigned i = 0; i < fw; i++) begin path.push_back(0); rq.push_back(1'b0); end
    path.push_back(0); rq.push_back(1'b1);
    path.push_back(1); rq.push_back(1'($urandom));
    case (op)
      6'h23, 6'h2B: begin
        path.push_back(2); rq.push_back(1'($urandom));
        for (int unsigned i = 0; i < mw; i++) begin
          path.push_back(op == 6'h23 ? 3 : 4); rq.push_back(1'b0);
        end
        path.push_back(op == 6'h23 ? 3 : 4); rq.push_back(1'b1);
        if (op == 6'h23) begin path.push_back(5); rq.push_back(1'($urandom)); end
      end
      6'h00: begin
        if (fn == 6'h08 || fn == 6'h09) begin path.push_back(11); rq.push_back(1'($urandom)); end
        else begin
          path.push_back(6); rq.push_back(1'($urandom));
          path.push_back(8); rq.push_back(1'($urandom));
        end
      end
      6'h04: begin path.push_back(9); rq.push_back(1'($urandom)); end
      6'h02, 6'h03: begin path.push_back(10); rq.push_back(1'($urandom)); end
      default: begin
        path.push_back(7); rq.push_back(1'($urandom));
        path.push_back(8); rq.push_back(1'($urandom));
      end
    endcase
    bus.OpCode = op;
    bus.Funct  = fn;
    foreach (path[k]) begin
      bus.mem_ready = rq[k];
      #1;
      n_checks++;
      if (bus.state_out !== path[k][3:0]) begin
        n_fail++;
        $display("FAIL %s state cyc %0d: got %0d exp %0d", name, k, bus.state_out, path[k]);
      end
      n_checks++;
      if (act_v !== exp_ctrl(path[k], op, fn, rq[k])) begin
        n_fail++;
        $display("FAIL %s ctrl cyc %0d: got %h exp %h", name, k, act_v,
                 exp_ctrl(path[k], op, fn, rq[k]));
      end
      @(posedge clk); #1;
    end
    exp_cnt++;
    exp_cnt_nt++;
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.state_out !== 4'd0 || bus.instr_count !== exp_cnt ||
        {bus.halted, bus.illegal, bus.timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s retire: state %0d cnt %0d flags %b exp state 0 cnt %0d flags 000",
               name, bus.state_out, bus.instr_count,
               {bus.halted, bus.illegal, bus.timeout}, exp_cnt);
    end
  endtask

  task automatic test_reset();
    bus.OpCode = 6'h00; bus.Funct = 6'h00;
    do_reset();
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.state_out !== 4'd0 || bus.instr_count !== 32'd0 ||
        {bus.halted, bus.illegal, bus.timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset: state %0d cnt %0d flags %b exp 0 0 000", bus.state_out,
               bus.instr_count, {bus.halted, bus.illegal, bus.timeout});
    end
  endtask

  task automatic test_addi();
    run_instr("addi", 6'h08, 6'h00, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", 6'h23, 6'h00, 3, 2);
    run_instr("sw_wait", 6'h2B, 6'h00, 1, 4);
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_instr("beq", 6'h04, 6'h00, 0, 0);
    run_instr("jal", 6'h03, 6'h00, 0, 0);
    n_checks++;
    if (bus.instr_count !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d exp 2", bus.instr_count);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[13] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A,
                            6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h02};
    logic [5:0] fns[11] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22,
                            6'h24, 6'h25, 6'h2A, 6'h08, 6'h09};
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = (i % 7 == 6) ? 6'h03 : ops[$urandom_range(0, 12)];
      fn = fns[$urandom_range(0, 10)];
      run_instr("random", op, fn, $urandom_range(0, 4), $urandom_range(0, 4));
    end
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr("pre_illegal", 6'h08, 6'h00, 0, 0);
    bus.OpCode = 6'h3F;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.state_out !== 4'd15 || {bus.halted, bus.illegal, bus.timeout} !== 3'b110) begin
      n_fail++;
      $display("FAIL trap_entry: state %0d flags %b exp 15 110", bus.state_out,
               {bus.halted, bus.illegal, bus.timeout});
    end
    n_checks++;
    if (bus_nt.state_out !== 4'd0 || {bus_nt.halted, bus_nt.illegal} !== 2'b01 ||
        bus_nt.instr_count !== exp_cnt_nt) begin
      n_fail++;
      $display("FAIL notrap: state %0d hi %b cnt %0d exp 0 01 %0d", bus_nt.state_out,
               {bus_nt.halted, bus_nt.illegal}, bus_nt.instr_count, exp_cnt_nt);
    end
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = 1'($urandom);
      bus.OpCode = 6'($urandom);
      #1;
      n_checks++;
      if (bus.state_out !== 4'd15 || act_v !== 23'd0 || bus.halted !== 1'b1 ||
          bus.instr_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL halt_hold %0d: state %0d ctrl %h halted %b cnt %0d", i,
                 bus.state_out, act_v, bus.halted, bus.instr_count);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    // fetch never answered: halts on the 16th waiting edge
    do_reset();
    bus.OpCode = 6'h23;
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 15) begin
        n_checks++;
        if (bus.state_out !== 4'd0 || bus.timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL to_early: state %0d timeout %b exp 0 0", bus.state_out, bus.timeout);
        end
      end
    end
    n_checks++;
    if (bus.state_out !== 4'd15 || {bus.halted, bus.timeout} !== 2'b11 || act_v !== 23'd0) begin
      n_fail++;
      $display("FAIL to_fetch: state %0d ht %b ctrl %h exp 15 11 0", bus.state_out,
               {bus.halted, bus.timeout}, act_v);
    end
    // ready on the last allowed cycle completes the fetch
    do_reset();
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.IRWrite, bus.PCWrite} !== 2'b11) begin
      n_fail++;
      $display("FAIL to_last_ready strobes: got %b exp 11", {bus.IRWrite, bus.PCWrite});
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.state_out !== 4'd1 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_last_ready: state %0d timeout %b exp 1 0", bus.state_out, bus.timeout);
    end
    // data read never answered
    do_reset();
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin @(posedge clk); #1; end
    n_checks++;
    if (bus.state_out !== 4'd15 || bus.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_memrd: state %0d timeout %b exp 15 1", bus.state_out, bus.timeout);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_instr("pre_mid", 6'h08, 6'h00, 0, 0);
    bus.OpCode = 6'h23;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.state_out !== 4'd3) begin
      n_fail++;
      $display("FAIL mid_wait_state: got %0d exp 3", bus.state_out);
    end
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_cnt = 0;
    exp_cnt_nt = 0;
    n_checks++;
    if (bus.state_out !== 4'd0 || bus.instr_count !== 32'd0 ||
        {bus.halted, bus.illegal, bus.timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: state %0d cnt %0d flags %b exp 0 0 000", bus.state_out,
               bus.instr_count, {bus.halted, bus.illegal, bus.timeout});
    end
  endtask

  initial begin
    bus.OpCode = 6'h00;
    bus.Funct = 6'h00;
    bus.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_back_to_back();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
